// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp codes, direction/state/fault enums for the traffic signal monitor
package traffic_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    typedef enum logic [1:0] {N = 2'd0, S = 2'd1, E = 2'd2, W = 2'd3} dir_t;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_GAP    = 3'd3,
        ST_FAULT  = 3'd4
    } mon_state_t;

    typedef enum logic [2:0] {
        FC_NONE        = 3'd0,
        FC_CONFLICT    = 3'd1,
        FC_ENCODING    = 3'd2,
        FC_ORDER       = 3'd3,
        FC_DWELL_SHORT = 3'd4,
        FC_DWELL_LONG  = 3'd5,
        FC_ALLRED_LONG = 3'd6,
        FC_NO_START    = 3'd7
    } fault_code_t;

    function automatic logic more_than_one(logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/traffic_signal_monitor_if.sv
// rtl/traffic_signal_monitor_if.sv - lamp buses into the monitor and gated lamp/status outputs
interface traffic_signal_monitor_if;
    logic [2:0] north_dir;
    logic [2:0] south_dir;
    logic [2:0] east_dir;
    logic [2:0] west_dir;
    logic [2:0] safe_north;
    logic [2:0] safe_south;
    logic [2:0] safe_east;
    logic [2:0] safe_west;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] active_dir;
    logic [3:0] remaining;

    modport master (
        output north_dir, south_dir, east_dir, west_dir,
        input  safe_north, safe_south, safe_east, safe_west,
        input  fault, fault_code, active_dir, remaining
    );

    modport slave (
        input  north_dir, south_dir, east_dir, west_dir,
        output safe_north, safe_south, safe_east, safe_west,
        output fault, fault_code, active_dir, remaining
    );
endinterface

// File: rtl/lamp_decode.sv
// rtl/lamp_decode.sv - one-hot lamp code classifier
module lamp_decode
    import traffic_pkg::*;
(
    input  logic [2:0] code,
    output logic       valid,
    output logic       is_green,
    output logic       is_yellow,
    output logic       is_red
);
    assign is_green  = (code == GREEN);
    assign is_yellow = (code == YELLOW);
    assign is_red    = (code == RED);
    assign valid     = is_green | is_yellow | is_red;
endmodule

// File: rtl/traffic_signal_monitor.sv
// rtl/traffic_signal_monitor.sv - phase/dwell safety checker with flashing-red failsafe lamp gate
module traffic_signal_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC   = 10,
    parameter int YELLOW_CYC  = 5,
    parameter int ALLRED_MAX  = 2,
    parameter int ARM_TIMEOUT = 20
) (
    input logic                     clk_out,
    input logic                     reset,
    traffic_signal_monitor_if.slave mon
);
    logic [2:0] bus [4];
    logic [3:0] valid, is_green, is_yellow, is_red;

    assign bus[0] = mon.north_dir;
    assign bus[1] = mon.south_dir;
    assign bus[2] = mon.east_dir;
    assign bus[3] = mon.west_dir;

    for (genvar i = 0; i < 4; i++) begin : g_dec
        lamp_decode u_dec (
            .code      (bus[i]),
            .valid     (valid[i]),
            .is_green  (is_green[i]),
            .is_yellow (is_yellow[i]),
            .is_red    (is_red[i])
        );
    end

    mon_state_t  state_q, state_n;
    dir_t        dir_q, dir_n, nxt_dir;
    logic [3:0]  dwell_q, dwell_n, gap_q, gap_n;
    logic [7:0]  arm_q, arm_n;
    logic [2:0]  safe_q [4];
    logic [2:0]  safe_n [4];
    logic        fault_q, fault_n, raise;
    fault_code_t fcode_q, fcode_n, code_n;
    logic [1:0]  active_q, active_n;
    logic [3:0]  remain_q, remain_n;
    logic        all_valid, all_red, conflict, start;

    assign nxt_dir   = dir_t'(dir_q + 2'd1);
    assign all_valid = &valid;
    assign all_red   = &is_red;
    assign conflict  = more_than_one(~is_red);
    assign start     = is_green[0] & is_red[1] & is_red[2] & is_red[3];

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q  <= ST_ARM;
            dir_q    <= N;
            dwell_q  <= 4'd0;
            gap_q    <= 4'd0;
            arm_q    <= 8'd0;
            fault_q  <= 1'b0;
            fcode_q  <= FC_NONE;
            active_q <= 2'd0;
            remain_q <= 4'd0;
            for (int i = 0; i < 4; i++) safe_q[i] <= RED;
        end else begin
            state_q  <= state_n;
            dir_q    <= dir_n;
            dwell_q  <= dwell_n;
            gap_q    <= gap_n;
            arm_q    <= arm_n;
            fault_q  <= fault_n;
            fcode_q  <= fcode_n;
            active_q <= active_n;
            remain_q <= remain_n;
            for (int i = 0; i < 4; i++) safe_q[i] <= safe_n[i];
        end
    end

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        dwell_n = dwell_q;
        gap_n   = gap_q;
        arm_n   = arm_q;
        raise   = 1'b0;
        code_n  = FC_NONE;

        case (state_q)
            ST_ARM: begin
                if (start) begin
                    state_n = ST_GREEN;
                    dir_n   = N;
                    dwell_n = 4'd1;
                    arm_n   = 8'd0;
                end else if (arm_q == 8'(ARM_TIMEOUT - 1)) begin
                    raise  = 1'b1;
                    code_n = FC_NO_START;
                end else begin
                    arm_n = arm_q + 8'd1;
                end
            end
            ST_FAULT: ;
            default: begin
                // Encoding beats conflict beats sequencing; only one code is ever latched.
                if (!all_valid) begin
                    raise  = 1'b1;
                    code_n = FC_ENCODING;
                end else if (conflict) begin
                    raise  = 1'b1;
                    code_n = FC_CONFLICT;
                end else begin
                    case (state_q)
                        ST_GREEN: begin
                            if (is_green[dir_q]) begin
                                if (dwell_q < 4'(GREEN_CYC)) dwell_n = dwell_q + 4'd1;
                                else begin raise = 1'b1; code_n = FC_DWELL_LONG; end
                            end else if (is_yellow[dir_q]) begin
                                if (dwell_q == 4'(GREEN_CYC)) begin
                                    state_n = ST_YELLOW;
                                    dwell_n = 4'd1;
                                end else begin raise = 1'b1; code_n = FC_DWELL_SHORT; end
                            end else begin
                                raise  = 1'b1;
                                code_n = FC_ORDER;
                            end
                        end
                        ST_YELLOW: begin
                            if (is_yellow[dir_q]) begin
                                if (dwell_q < 4'(YELLOW_CYC)) dwell_n = dwell_q + 4'd1;
                                else begin raise = 1'b1; code_n = FC_DWELL_LONG; end
                            end else if (is_green[nxt_dir] || all_red) begin
                                if (dwell_q != 4'(YELLOW_CYC)) begin
                                    raise  = 1'b1;
                                    code_n = FC_DWELL_SHORT;
                                end else if (all_red) begin
                                    state_n = ST_GAP;
                                    gap_n   = 4'd1;
                                end else begin
                                    state_n = ST_GREEN;
                                    dir_n   = nxt_dir;
                                    dwell_n = 4'd1;
                                end
                            end else begin
                                raise  = 1'b1;
                                code_n = FC_ORDER;
                            end
                        end
                        ST_GAP: begin
                            if (all_red) begin
                                if (gap_q < 4'(ALLRED_MAX)) gap_n = gap_q + 4'd1;
                                else begin raise = 1'b1; code_n = FC_ALLRED_LONG; end
                            end else if (is_green[nxt_dir]) begin
                                state_n = ST_GREEN;
                                dir_n   = nxt_dir;
                                dwell_n = 4'd1;
                            end else begin
                                raise  = 1'b1;
                                code_n = FC_ORDER;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        fault_n = fault_q;
        fcode_n = fcode_q;
        if (raise) begin
            state_n = ST_FAULT;
            fault_n = 1'b1;
            fcode_n = code_n;
        end

        // Lamps: red in ARM, flashing red in FAULT (red on entry), otherwise the checked sample.
        for (int i = 0; i < 4; i++) begin
            if (state_n == ST_FAULT)
                safe_n[i] = (state_q == ST_FAULT && safe_q[0] == RED) ? 3'b000 : RED;
            else if (state_n == ST_ARM)
                safe_n[i] = RED;
            else
                safe_n[i] = bus[i];
        end

        case (state_n)
            ST_GREEN:  remain_n = 4'(GREEN_CYC) - dwell_n;
            ST_YELLOW: remain_n = 4'(YELLOW_CYC) - dwell_n;
            default:   remain_n = 4'd0;
        endcase

        case (state_n)
            ST_ARM:    active_n = 2'd0;
            ST_GAP:    active_n = dir_n + 2'd1;
            ST_FAULT:  active_n = active_q;
            default:   active_n = dir_n;
        endcase
    end

    assign mon.safe_north = safe_q[0];
    assign mon.safe_south = safe_q[1];
    assign mon.safe_east  = safe_q[2];
    assign mon.safe_west  = safe_q[3];
    assign mon.fault      = fault_q;
    assign mon.fault_code = fcode_q;
    assign mon.active_dir = active_q;
    assign mon.remaining  = remain_q;

endmodule
